// File: rtl/cgol_pkg.sv
// Shared constants, FSM encoding and neighbour addressing for the Game of Life engine.
package cgol_pkg;

    localparam logic [3:0] BIRTH_N    = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] idx;
    } nb_t;

    // Flat index of neighbour (r+dr, c+dc); invalid when it falls off a non-wrapping edge.
    function automatic nb_t neighbour_idx(input int r, input int c, input int dr, input int dc,
                                          input int width, input int height, input logic wrap);
        nb_t res;
        int  rr;
        int  cc;
        rr = r + dr;
        cc = c + dc;
        res.valid = 1'b1;
        if (wrap) begin
            rr = (rr + height) % height;
            cc = (cc + width) % width;
        end else if (rr < 0 || rr >= height || cc < 0 || cc >= width) begin
            res.valid = 1'b0;
            rr = 0;
            cc = 0;
        end else begin
            res.valid = 1'b1;
        end
        res.idx = 32'(rr * width + cc);
        return res;
    endfunction

endpackage

// File: rtl/cgol_cell_rule.sv
// Single-cell Life rule: birth on exactly three neighbours, survival on two or three.
module cgol_cell_rule
    import cgol_pkg::*;
(
    input  logic       centre,
    input  logic [7:0] sides,
    output logic       nexton
);

    logic [3:0] count_s;

    // Population count of the eight neighbours, then apply the rule.
    always_comb begin
        count_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            count_s = count_s + {3'b000, sides[i]};
        end
        if (centre) begin
            nexton = (count_s >= SURVIVE_LO) && (count_s <= SURVIVE_HI);
        end else begin
            nexton = (count_s == BIRTH_N);
        end
    end

endmodule

// File: rtl/cgol_grid_engine.sv
// Whole-grid Game of Life engine: one generation per clock, with host load,
// generation budget and early stop on stable or extinct grids.
module cgol_grid_engine
    import cgol_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int WRAP   = 1,
    parameter int GEN_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(HEIGHT)-1:0]  wr_row,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       clear,
    input  logic                       start,
    input  logic [GEN_W-1:0]           gens,
    output logic                       busy,
    output logic                       done,
    output logic                       stable,
    output logic                       extinct,
    output logic [GEN_W-1:0]           gen_count,
    output logic [WIDTH*HEIGHT-1:0]    grid
);

    localparam int CELLS = WIDTH * HEIGHT;

    state_e              state_r;
    logic [CELLS-1:0]    grid_r;
    logic [CELLS-1:0]    next_grid_s;
    logic [GEN_W-1:0]    gen_count_r;
    logic [GEN_W-1:0]    remaining_r;
    logic                done_r;
    logic                stable_r;
    logic                extinct_r;
    logic                row_ok_s;

    // One rule instance per cell, wired to its neighbours at elaboration time.
    for (genvar r = 0; r < HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < WIDTH; c++) begin : g_col
            logic [7:0] sides_s;
            for (genvar k = 0; k < 9; k++) begin : g_nb
                if (k != 4) begin : g_side
                    localparam nb_t NB   = neighbour_idx(r, c, (k / 3) - 1, (k % 3) - 1,
                                                         WIDTH, HEIGHT, WRAP != 0);
                    localparam int  SIDE = (k < 4) ? k : k - 1;
                    localparam int  IDX  = int'(NB.idx);
                    if (NB.valid) begin : g_live
                        assign sides_s[SIDE] = grid_r[IDX];
                    end else begin : g_dead
                        assign sides_s[SIDE] = 1'b0;
                    end
                end
            end
            cgol_cell_rule u_rule (
                .centre (grid_r[r*WIDTH+c]),
                .sides  (sides_s),
                .nexton (next_grid_s[r*WIDTH+c])
            );
        end
    end

    assign row_ok_s = (int'(wr_row) < HEIGHT);

    // Control FSM, grid storage, generation counter and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            grid_r      <= '0;
            gen_count_r <= '0;
            remaining_r <= '0;
            done_r      <= 1'b0;
            stable_r    <= 1'b0;
            extinct_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        stable_r  <= 1'b0;
                        extinct_r <= 1'b0;
                        if (gens == '0) begin
                            done_r <= 1'b1;
                        end else begin
                            remaining_r <= gens;
                            state_r     <= ST_RUN;
                        end
                    end else if (clear) begin
                        grid_r      <= '0;
                        gen_count_r <= '0;
                        stable_r    <= 1'b0;
                        extinct_r   <= 1'b0;
                    end else if (wr_en && row_ok_s) begin
                        grid_r[int'(wr_row)*WIDTH +: WIDTH] <= wr_data;
                    end else begin
                        grid_r <= grid_r;
                    end
                end
                ST_RUN: begin
                    // Early-stop checks precede the commit, so a stop costs no generation.
                    if (grid_r == '0) begin
                        extinct_r <= 1'b1;
                        done_r    <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else if (next_grid_s == grid_r) begin
                        stable_r <= 1'b1;
                        done_r   <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        grid_r      <= next_grid_s;
                        gen_count_r <= gen_count_r + GEN_W'(1);
                        remaining_r <= remaining_r - GEN_W'(1);
                        if (remaining_r == GEN_W'(1)) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_r == ST_RUN);
    assign done      = done_r;
    assign stable    = stable_r;
    assign extinct   = extinct_r;
    assign gen_count = gen_count_r;
    assign grid      = grid_r;

endmodule
